// File: rtl/centurion_pkg.sv
// Shared definitions for the Centurion Tang Nano build: bus widths,
// bridge FSM state encoding and a byte-lane helper.
package centurion_pkg;

  localparam int CPU_ADDR_W   = 19;
  localparam int PSRAM_ADDR_W = 22;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_ACK   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Odd byte addresses live in the upper half of a PSRAM word.
  function automatic logic [7:0] byte_lane(input logic hi, input logic [15:0] word);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/read_buffer_1w.sv
// Single-entry read buffer: one tagged 16-bit PSRAM word, filled on read
// completion and byte-merged by write-through traffic to the same word.
module read_buffer_1w
  import centurion_pkg::*;
#(
  parameter int TAG_W  = 21,
  parameter bit ENABLE = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [15:0]      data,
  input  logic             wr_en,
  input  logic             wr_hi,
  input  logic [7:0]       wr_byte,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [15:0]      fill_data
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  assign hit = valid && (tag == lookup_tag);

  // With ENABLE cleared the entry never becomes valid, so every read misses.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill_en) begin
      valid <= ENABLE;
      tag   <= fill_tag;
      data  <= fill_data;
    end else if (wr_en && hit) begin
      if (wr_hi) data[15:8] <= wr_byte;
      else       data[7:0]  <= wr_byte;
    end
  end

endmodule

// File: rtl/psram_bus_bridge.sv
// Maps a window of the CPU6 byte bus onto the PsramController word handshake,
// stalling the CPU clock enable while a PSRAM transaction is outstanding.
module psram_bus_bridge #(
  parameter int                      ADDR_W       = centurion_pkg::CPU_ADDR_W,
  parameter int                      WIN_BITS     = 16,
  parameter logic [ADDR_W-1:0]       BASE         = '0,
  parameter int                      PSRAM_ADDR_W = centurion_pkg::PSRAM_ADDR_W,
  parameter logic [PSRAM_ADDR_W-1:0] PSRAM_BASE   = '0,
  parameter bit                      READ_BUFFER  = 1'b1,
  parameter int                      ACK_TIMEOUT  = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [ADDR_W-1:0]       bus_addr,
  input  logic                    bus_valid,
  input  logic                    bus_we,
  input  logic [7:0]              bus_wdata,
  output logic                    bus_sel,
  output logic [7:0]              bus_rdata,
  output logic                    cpu_stall,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    mem_byte_write,
  output logic [PSRAM_ADDR_W-1:0] mem_addr,
  output logic [15:0]             mem_din,
  input  logic [15:0]             mem_dout,
  input  logic                    mem_busy
);
  import centurion_pkg::*;

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [2:0]              state;
  logic [CNT_W-1:0]        ack_cnt;
  logic                    we_q;
  logic [7:0]              rdata_q;
  logic [PSRAM_ADDR_W-1:0] req_addr;
  logic                    buf_hit;
  logic [15:0]             buf_data;
  logic                    want_psram;
  logic                    accept;
  logic                    read_hit;
  logic                    fill_en;

  assign bus_sel  = ((bus_addr >> WIN_BITS) == (BASE >> WIN_BITS));
  assign req_addr = PSRAM_BASE + {{(PSRAM_ADDR_W-WIN_BITS){1'b0}}, bus_addr[WIN_BITS-1:0]};

  assign want_psram = bus_valid && bus_sel && (bus_we || !buf_hit);
  assign accept     = (state == ST_IDLE) && want_psram;
  assign read_hit   = (state == ST_IDLE) && bus_valid && bus_sel && !bus_we && buf_hit;
  assign fill_en    = (state == ST_WAIT) && !mem_busy && !we_q;

  // The stall term on the request itself keeps the CPU frozen on the latch cycle.
  assign cpu_stall = ((state != ST_IDLE) && (state != ST_DONE)) || want_psram;
  assign bus_rdata = read_hit ? byte_lane(req_addr[0], buf_data) : rdata_q;

  read_buffer_1w #(
    .TAG_W  (PSRAM_ADDR_W-1),
    .ENABLE (READ_BUFFER)
  ) u_buf (
    .clock      (clock),
    .resetn     (resetn),
    .lookup_tag (req_addr[PSRAM_ADDR_W-1:1]),
    .hit        (buf_hit),
    .data       (buf_data),
    .wr_en      (accept && bus_we),
    .wr_hi      (req_addr[0]),
    .wr_byte    (bus_wdata),
    .fill_en    (fill_en),
    .fill_tag   (mem_addr[PSRAM_ADDR_W-1:1]),
    .fill_data  (mem_dout)
  );

  // Requests are one-cycle registered pulses; ACK retries if busy never rises.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      ack_cnt        <= '0;
      we_q           <= 1'b0;
      rdata_q        <= 8'h00;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte_write <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= 16'h0000;
    end else begin
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (read_hit) rdata_q <= byte_lane(req_addr[0], buf_data);
          if (accept) begin
            mem_addr <= req_addr;
            mem_din  <= {bus_wdata, bus_wdata};
            we_q     <= bus_we;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!mem_busy) begin
            mem_read       <= !we_q;
            mem_write      <= we_q;
            mem_byte_write <= we_q;
            ack_cnt        <= '0;
            state          <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (mem_busy)                                state   <= ST_WAIT;
          else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) state   <= ST_ISSUE;
          else                                         ack_cnt <= ack_cnt + CNT_W'(1);
        end
        ST_WAIT: begin
          if (!mem_busy) begin
            if (!we_q) rdata_q <= byte_lane(mem_addr[0], mem_dout);
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_bus_bridge.sv
// Self-checking bench for psram_bus_bridge: a behavioural PSRAM controller plus
// a byte-level memory/buffer reference model, driven by directed and random accesses.
module tb_psram_bus_bridge;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [18:0] bus_addr = '0;
  logic        bus_valid = 1'b0;
  logic        bus_we = 1'b0;
  logic [7:0]  bus_wdata = '0;
  logic        bus_sel;
  logic [7:0]  bus_rdata;
  logic        cpu_stall;
  logic        mem_read, mem_write, mem_byte_write;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = 16'h0000;
  logic        mem_busy = 1'b0;

  int total = 0;
  int bad   = 0;

  // Controller model state and request log
  int          busy_len = 6;
  int          busy_left = 0;
  bit          ignore_next = 0;
  int          rd_reqs = 0;
  int          wr_reqs = 0;
  int          busy_violations = 0;
  logic [21:0] last_addr = '0;
  logic [15:0] last_din = '0;
  logic        last_bw = 1'b0;
  logic [15:0] ctrl_mem [int];

  // Reference model: byte memory and the single buffered word
  logic [7:0]  ref_mem [int];
  bit          ref_buf_valid = 0;
  int          ref_buf_word = 0;

  psram_bus_bridge dut (
    .clock          (clock),
    .resetn         (resetn),
    .bus_addr       (bus_addr),
    .bus_valid      (bus_valid),
    .bus_we         (bus_we),
    .bus_wdata      (bus_wdata),
    .bus_sel        (bus_sel),
    .bus_rdata      (bus_rdata),
    .cpu_stall      (cpu_stall),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_write (mem_byte_write),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_busy       (mem_busy)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] seed_word(int w);
    return 16'(w * 40503 + 12345);
  endfunction

  function automatic logic [15:0] ctrl_word(int w);
    if (ctrl_mem.exists(w)) return ctrl_mem[w];
    return seed_word(w);
  endfunction

  function automatic logic [7:0] ref_byte(int a);
    logic [15:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = seed_word(a >> 1);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // PSRAM controller: busy rises the cycle after a request and lasts busy_len cycles.
  always @(posedge clock) begin
    logic [15:0] w;
    int          key;
    if (mem_read || mem_write) begin
      if (mem_busy) busy_violations++;
      if (mem_read) rd_reqs++;
      else          wr_reqs++;
      last_addr = mem_addr;
      last_din  = mem_din;
      last_bw   = mem_byte_write;
      key = int'(mem_addr >> 1);
      if (ignore_next) begin
        ignore_next = 0;
      end else if (!mem_busy) begin
        if (mem_write) begin
          w = ctrl_word(key);
          if (mem_addr[0]) w[15:8] = mem_din[15:8];
          else             w[7:0]  = mem_din[7:0];
          ctrl_mem[key] = w;
        end else begin
          mem_dout <= ctrl_word(key);
        end
        mem_busy  <= 1'b1;
        busy_left = busy_len - 1;
      end
    end else if (mem_busy) begin
      if (busy_left == 0) mem_busy <= 1'b0;
      else                busy_left--;
    end
  end

  // One CPU access; stall_cycles counts cycles with cpu_stall high from the request cycle.
  task automatic applyStimulus(input logic [18:0] a, input bit we, input logic [7:0] wd,
                               output logic [7:0] rd, output int stall_cycles,
                               output bit sel, output bit timed_out);
    int n;
    @(negedge clock);
    bus_addr = a; bus_we = we; bus_wdata = wd; bus_valid = 1'b1;
    #1;
    sel = bus_sel; stall_cycles = 0; timed_out = 0;
    if (!cpu_stall) begin
      rd = bus_rdata;
      @(negedge clock);
      bus_valid = 1'b0;
    end else begin
      stall_cycles = 1;
      @(negedge clock);
      bus_valid = 1'b0;
      #1;
      n = 0;
      while (cpu_stall && n < 300) begin
        stall_cycles++;
        @(negedge clock); #1;
        n++;
      end
      timed_out = cpu_stall;
      rd = bus_rdata;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (mem_read !== 1'b0)       begin bad++; $display("[TB] FAIL reset_mem_read: got %b expected 0", mem_read); end
    total++; if (mem_write !== 1'b0)      begin bad++; $display("[TB] FAIL reset_mem_write: got %b expected 0", mem_write); end
    total++; if (mem_byte_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_byte_write: got %b expected 0", mem_byte_write); end
    total++; if (mem_addr !== 22'h0)      begin bad++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    total++; if (mem_din !== 16'h0)       begin bad++; $display("[TB] FAIL reset_mem_din: got %h expected 0", mem_din); end
    total++; if (bus_rdata !== 8'h0)      begin bad++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus_rdata); end
    total++; if (cpu_stall !== 1'b0)      begin bad++; $display("[TB] FAIL reset_stall: got %b expected 0", cpu_stall); end
    resetn = 1'b1;
    ref_buf_valid = 0;
  endtask

  task automatic test_read_miss;
    logic [7:0] rd; int st; bit sel, to; int r0;
    ctrl_mem[32'h91] = 16'hBEEF;
    ref_mem[32'h123] = 8'hBE;
    ref_mem[32'h122] = 8'hEF;
    busy_len = 6;
    r0 = rd_reqs;
    applyStimulus(19'h00123, 1'b0, 8'h00, rd, st, sel, to);
    total++; if (to)               begin bad++; $display("[TB] FAIL miss_timeout: stall still high after bound"); end
    total++; if (rd_reqs - r0 != 1) begin bad++; $display("[TB] FAIL miss_read_count: got %0d expected 1", rd_reqs - r0); end
    total++; if (last_addr !== 22'h000123) begin bad++; $display("[TB] FAIL miss_addr: got %h expected 000123", last_addr); end
    total++; if (rd !== 8'hBE)     begin bad++; $display("[TB] FAIL miss_rdata: got %h expected be", rd); end
    total++; if (st != busy_len + 4) begin bad++; $display("[TB] FAIL miss_latency: got %0d expected %0d", st, busy_len + 4); end
    ref_buf_valid = 1; ref_buf_word = 32'h91;
  endtask

  task automatic test_read_hit;
    logic [7:0] rd; int st; bit sel, to; int r0;
    r0 = rd_reqs;
    applyStimulus(19'h00122, 1'b0, 8'h00, rd, st, sel, to);
    total++; if (st != 0)           begin bad++; $display("[TB] FAIL hit_stall: got %0d cycles expected 0", st); end
    total++; if (rd !== 8'hEF)      begin bad++; $display("[TB] FAIL hit_rdata: got %h expected ef", rd); end
    total++; if (rd_reqs != r0)     begin bad++; $display("[TB] FAIL hit_no_read: got %0d reads expected 0", rd_reqs - r0); end
  endtask

  task automatic test_write_through;
    logic [7:0] rd; int st; bit sel, to; int r0, w0;
    r0 = rd_reqs; w0 = wr_reqs;
    applyStimulus(19'h00122, 1'b1, 8'h5A, rd, st, sel, to);
    ref_mem[32'h122] = 8'h5A;
    total++; if (to || st == 0)     begin bad++; $display("[TB] FAIL wr_stall: got %0d cycles expected nonzero", st); end
    total++; if (wr_reqs - w0 != 1) begin bad++; $display("[TB] FAIL wr_count: got %0d expected 1", wr_reqs - w0); end
    total++; if (last_bw !== 1'b1)  begin bad++; $display("[TB] FAIL wr_byte_write: got %b expected 1", last_bw); end
    total++; if (last_din !== 16'h5A5A) begin bad++; $display("[TB] FAIL wr_din: got %h expected 5a5a", last_din); end
    total++; if (last_addr !== 22'h000122) begin bad++; $display("[TB] FAIL wr_addr: got %h expected 000122", last_addr); end
    total++; if (ctrl_mem[32'h91] !== 16'hBE5A) begin bad++; $display("[TB] FAIL wr_psram_word: got %h expected be5a", ctrl_mem[32'h91]); end
    applyStimulus(19'h00122, 1'b0, 8'h00, rd, st, sel, to);
    total++; if (rd !== 8'h5A || st != 0) begin bad++; $display("[TB] FAIL wr_readback: got %h/%0d expected 5a/0", rd, st); end
    applyStimulus(19'h00123, 1'b0, 8'h00, rd, st, sel, to);
    total++; if (rd !== 8'hBE || st != 0) begin bad++; $display("[TB] FAIL wr_other_lane: got %h/%0d expected be/0", rd, st); end
    total++; if (rd_reqs != r0)     begin bad++; $display("[TB] FAIL wr_no_read: got %0d reads expected 0", rd_reqs - r0); end
  endtask

  task automatic test_retry;
    logic [7:0] rd; int st; bit sel, to; int r0;
    logic [7:0] exp;
    r0 = rd_reqs;
    exp = ref_byte(32'h400);
    ignore_next = 1;
    applyStimulus(19'h00400, 1'b0, 8'h00, rd, st, sel, to);
    total++; if (to)                begin bad++; $display("[TB] FAIL retry_timeout: stall still high after bound"); end
    total++; if (rd_reqs - r0 != 2) begin bad++; $display("[TB] FAIL retry_count: got %0d expected 2", rd_reqs - r0); end
    total++; if (rd !== exp)        begin bad++; $display("[TB] FAIL retry_rdata: got %h expected %h", rd, exp); end
    total++; if (st != busy_len + 9) begin bad++; $display("[TB] FAIL retry_latency: got %0d expected %0d", st, busy_len + 9); end
    ref_buf_valid = 1; ref_buf_word = 32'h200;
  endtask

  task automatic test_window;
    logic [7:0] rd; int st; bit sel, to; int r0, w0;
    logic [7:0] exp;
    r0 = rd_reqs; w0 = wr_reqs;
    applyStimulus(19'h10000, 1'b0, 8'h00, rd, st, sel, to);
    total++; if (sel !== 1'b0 || st != 0) begin bad++; $display("[TB] FAIL outwin_read: got sel=%b stall=%0d expected 0/0", sel, st); end
    applyStimulus(19'h7FFFF, 1'b1, 8'h33, rd, st, sel, to);
    total++; if (sel !== 1'b0 || st != 0) begin bad++; $display("[TB] FAIL outwin_write: got sel=%b stall=%0d expected 0/0", sel, st); end
    repeat (3) @(negedge clock);
    total++; if (rd_reqs != r0 || wr_reqs != w0) begin bad++; $display("[TB] FAIL outwin_activity: got %0d/%0d requests expected 0/0", rd_reqs - r0, wr_reqs - w0); end
    exp = ref_byte(32'hFFFF);
    applyStimulus(19'h0FFFF, 1'b0, 8'h00, rd, st, sel, to);
    total++; if (sel !== 1'b1 || rd !== exp) begin bad++; $display("[TB] FAIL topwin_read: got sel=%b data=%h expected 1/%h", sel, rd, exp); end
    total++; if (last_addr !== 22'h00FFFF) begin bad++; $display("[TB] FAIL topwin_addr: got %h expected 00ffff", last_addr); end
    ref_buf_valid = 1; ref_buf_word = 32'h7FFF;
  endtask

  task automatic test_random;
    logic [7:0] rd, wd, exp; int st; bit sel, to, we, ign, exp_hit, outw; int r0, w0, key;
    logic [18:0] a;
    for (int i = 0; i < 60; i++) begin
      outw = ($urandom_range(0, 7) == 0);
      a = outw ? 19'($urandom_range(32'h10000, 32'h7FFFF)) : 19'(32'h200 + $urandom_range(0, 15));
      we = $urandom_range(0, 2) == 0;
      wd = 8'($urandom);
      ign = ($urandom_range(0, 5) == 0) && !outw;
      busy_len = $urandom_range(1, 5);
      key = int'(a);
      exp = ref_byte(key);
      exp_hit = !we && ref_buf_valid && (ref_buf_word == (key >> 1));
      ignore_next = ign;
      r0 = rd_reqs; w0 = wr_reqs;
      applyStimulus(a, we, wd, rd, st, sel, to);
      if (outw) begin
        total++; if (sel !== 1'b0 || st != 0 || rd_reqs != r0 || wr_reqs != w0)
          begin bad++; $display("[TB] FAIL rnd_outwin a=%h: got sel=%b stall=%0d req=%0d expected 0/0/0", a, sel, st, rd_reqs - r0 + wr_reqs - w0); end
        continue;
      end
      total++; if (to) begin bad++; $display("[TB] FAIL rnd_timeout a=%h: stall still high after bound", a); end
      if (we) begin
        ref_mem[key] = wd;
        total++; if (wr_reqs - w0 != 1 + int'(ign) || rd_reqs != r0 || last_din !== {wd, wd} || last_addr !== 22'(a))
          begin bad++; $display("[TB] FAIL rnd_write a=%h: got wr=%0d din=%h addr=%h expected %0d/%h%h/%h", a, wr_reqs - w0, last_din, last_addr, 1 + int'(ign), wd, wd, a); end
      end else begin
        total++; if (rd !== exp) begin bad++; $display("[TB] FAIL rnd_rdata a=%h: got %h expected %h", a, rd, exp); end
        if (exp_hit) begin
          total++; if (st != 0 || rd_reqs != r0) begin bad++; $display("[TB] FAIL rnd_hit a=%h: got stall=%0d reads=%0d expected 0/0", a, st, rd_reqs - r0); end
        end else begin
          total++; if (st == 0 || rd_reqs - r0 != 1 + int'(ign) || last_addr !== 22'(a))
            begin bad++; $display("[TB] FAIL rnd_miss a=%h: got stall=%0d reads=%0d addr=%h expected >0/%0d/%h", a, st, rd_reqs - r0, last_addr, 1 + int'(ign), a); end
          ref_buf_valid = 1; ref_buf_word = key >> 1;
        end
      end
      if (ign) ignore_next = 0;
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd; int st; bit sel, to; int n, r0;
    busy_len = 3;
    applyStimulus(19'h00123, 1'b0, 8'h00, rd, st, sel, to);
    ref_buf_valid = 1; ref_buf_word = 32'h91;
    busy_len = 20;
    @(negedge clock);
    bus_addr = 19'h00600; bus_we = 1'b0; bus_valid = 1'b1;
    @(negedge clock);
    bus_valid = 1'b0;
    n = 0;
    while (!mem_busy && n < 50) begin @(negedge clock); n++; end
    total++; if (mem_busy !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b expected 1", mem_busy); end
    busy_len = 3;
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    ref_buf_valid = 0;
    r0 = rd_reqs;
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_byte_write !== 1'b0)
      begin bad++; $display("[TB] FAIL rst_mid_requests: got %b%b%b expected 000", mem_read, mem_write, mem_byte_write); end
    total++; if (cpu_stall !== 1'b0 || bus_rdata !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid_idle: got stall=%b rdata=%h expected 0/00", cpu_stall, bus_rdata); end
    repeat (3) @(negedge clock);
    total++; if (rd_reqs != r0) begin bad++; $display("[TB] FAIL rst_mid_reissue: got %0d reads expected 0", rd_reqs - r0); end
    applyStimulus(19'h00123, 1'b0, 8'h00, rd, st, sel, to);
    total++; if (to || st == 0 || rd_reqs - r0 != 1) begin bad++; $display("[TB] FAIL rst_mid_miss: got stall=%0d reads=%0d expected >0/1", st, rd_reqs - r0); end
    total++; if (rd !== ref_byte(32'h123)) begin bad++; $display("[TB] FAIL rst_mid_rdata: got %h expected %h", rd, ref_byte(32'h123)); end
  endtask

  task automatic checkOutput;
    total++; if (busy_violations != 0) begin bad++; $display("[TB] FAIL req_while_busy: got %0d expected 0", busy_violations); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_through();
    test_retry();
    test_window();
    test_random();
    test_reset_mid();
    checkOutput();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
